// File: rtl/rr_arb4_stage.sv
// rr_arb4_stage
//
// Four-channel round-robin arbiter feeding a single registered output
// stage. Each cycle in which the output register can be (re)loaded, one
// requesting channel is granted. The search starts at a rotating pointer
// and ends at the pointer + 3 (mod 4). The granted word and its channel
// index appear on the outputs one cycle later.
//
// Ports
//   clk        in   1         single clock, rising edge
//   rst        in   1         synchronous, active-high reset
//   in_valid   in   4         per-channel request
//   in_data    in   [3:0][N]  per-channel data, channel i in in_data[i]
//   in_ready   out  4         one-hot accept of the granted channel (comb.)
//   out_valid  out  1         output register holds a word
//   out_ready  in   1         downstream accepts when out_valid is high
//   out_data   out  N         registered word of the granted channel
//   sel        out  2         channel index of the word in out_data
//
// State    | meaning
// ---------+-----------------------------------------------
// S_EMPTY  | output register holds no word (out_valid = 0)
// S_FULL   | output register holds a word  (out_valid = 1)

module rr_arb4_stage #(
    parameter int N = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [3:0]          in_valid,
    input  logic [3:0][N-1:0]   in_data,
    output logic [3:0]          in_ready,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [N-1:0]        out_data,
    output logic [1:0]          sel
);

    typedef enum logic {
        S_EMPTY = 1'b0,
        S_FULL  = 1'b1
    } state_t;

    state_t         state_q, state_d;
    logic [N-1:0]   data_q, data_d;
    logic [1:0]     sel_q, sel_d;
    logic [1:0]     ptr_q, ptr_d;

    logic           load_slot;
    logic           gnt_any;
    logic [1:0]     gnt_idx;
    logic           grant;

    // Rotating priority search: the first requester at ptr, ptr+1, ptr+2
    // or ptr+3. The 2-bit add wraps modulo 4 on its own.
    always_comb begin
        logic [1:0] cand;
        cand    = 2'd0;
        gnt_any = 1'b0;
        gnt_idx = ptr_q;
        for (int k = 0; k < 4; k++) begin
            cand = ptr_q + 2'(k);
            if (!gnt_any && in_valid[cand]) begin
                gnt_any = 1'b1;
                gnt_idx = cand;
            end
        end
    end

    // Reset masks the slot so that no grant is shown or taken on a reset edge.
    assign load_slot = !rst && ((state_q == S_EMPTY) || out_ready);
    assign grant     = load_slot && gnt_any;
    assign in_ready  = grant ? (4'b0001 << gnt_idx) : 4'b0000;

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        sel_d   = sel_q;
        ptr_d   = ptr_q;
        if (grant) begin
            state_d = S_FULL;
            data_d  = in_data[gnt_idx];
            sel_d   = gnt_idx;
            ptr_d   = gnt_idx + 2'd1;
        end else if (load_slot) begin
            // Word drained (or nothing held) and nothing to load.
            state_d = S_EMPTY;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_EMPTY;
            data_q  <= '0;
            sel_q   <= 2'd0;
            ptr_q   <= 2'd0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            sel_q   <= sel_d;
            ptr_q   <= ptr_d;
        end
    end

    assign out_valid = (state_q == S_FULL);
    assign out_data  = data_q;
    assign sel       = sel_q;

endmodule

// File: tb/tb_rr_arb4_stage.sv
module tb_rr_arb4_stage;

    localparam int N = 4;

    logic               clk;
    logic               rst;
    logic [3:0]         in_valid;
    logic [3:0][N-1:0]  in_data;
    logic [3:0]         in_ready;
    logic               out_valid;
    logic               out_ready;
    logic [N-1:0]       out_data;
    logic [1:0]         sel;

    int total = 0;
    int bad   = 0;

    rr_arb4_stage #(.N(N)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .sel       (sel)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Inputs change 1 time unit after the rising edge; outputs are sampled there too.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference state for the random phase
    logic [1:0]     m_ptr;
    logic           m_full;
    logic [N-1:0]   m_data;
    logic [1:0]     m_sel;
    logic           m_slot;
    logic           m_gnt;
    logic [1:0]     m_gidx;
    logic [3:0]     m_rdy;
    int             sent [4];
    int             recv [4];
    int             waits [4];

    initial begin
        logic [1:0] want;
        rst       = 1'b1;
        in_valid  = 4'b0000;
        out_ready = 1'b0;
        in_data   = {4'hD, 4'hC, 4'hB, 4'hA};

        // ---- reset ----
        tick();
        tick();
        in_valid = 4'b1111;
        #1;
        chk("rst_in_ready", 32'(in_ready), 32'h0);
        chk("rst_out_valid", 32'(out_valid), 32'h0);
        chk("rst_out_data", 32'(out_data), 32'h0);
        chk("rst_sel", 32'(sel), 32'h0);
        tick();

        // ---- all channels requesting, sink always ready: 0,1,2,3,0,1,2,3 ----
        rst       = 1'b0;
        out_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            want = 2'(k);
            #1;
            chk("rr_in_ready", 32'(in_ready), 32'(4'b0001 << want));
            tick();
            chk("rr_sel", 32'(sel), 32'(want));
            chk("rr_out_valid", 32'(out_valid), 32'h1);
            chk("rr_out_data", 32'(out_data), 32'(in_data[want]));
        end

        // ---- drain with no requests: FULL -> EMPTY, data and sel hold ----
        in_valid = 4'b0000;
        #1;
        chk("drain_in_ready", 32'(in_ready), 32'h0);
        tick();
        chk("drain_out_valid", 32'(out_valid), 32'h0);
        chk("drain_out_data", 32'(out_data), 32'hD);
        chk("drain_sel", 32'(sel), 32'h3);

        // ---- EMPTY and idle holds ----
        tick();
        chk("idle_out_valid", 32'(out_valid), 32'h0);
        chk("idle_sel", 32'(sel), 32'h3);

        // ---- single request on ch2, sink stalled: load then hold 5 cycles ----
        in_data[2] = 4'b0111;
        in_data[0] = 4'h5;
        in_valid   = 4'b0100;
        out_ready  = 1'b0;
        #1;
        chk("ld2_in_ready", 32'(in_ready), 32'b0100);
        tick();
        chk("ld2_out_data", 32'(out_data), 32'h7);
        chk("ld2_sel", 32'(sel), 32'h2);
        chk("ld2_out_valid", 32'(out_valid), 32'h1);
        in_data[2] = 4'hF;
        in_valid   = 4'b0101;
        for (int k = 0; k < 5; k++) begin
            #1;
            chk("hold_in_ready", 32'(in_ready), 32'h0);
            tick();
            chk("hold_out_data", 32'(out_data), 32'h7);
            chk("hold_sel", 32'(sel), 32'h2);
            chk("hold_out_valid", 32'(out_valid), 32'h1);
        end

        // ---- pointer at 3, requests on 0 and 1: wrap to 0, then 1 ----
        in_data   = {4'hD, 4'hC, 4'hB, 4'hA};
        in_valid  = 4'b0011;
        out_ready = 1'b1;
        #1;
        chk("wrap0_in_ready", 32'(in_ready), 32'b0001);
        tick();
        chk("wrap0_sel", 32'(sel), 32'h0);
        chk("wrap0_out_data", 32'(out_data), 32'hA);
        #1;
        chk("wrap1_in_ready", 32'(in_ready), 32'b0010);
        tick();
        chk("wrap1_sel", 32'(sel), 32'h1);
        chk("wrap1_out_data", 32'(out_data), 32'hB);

        // ---- reset while FULL with everything requesting ----
        rst      = 1'b1;
        in_valid = 4'b1111;
        #1;
        chk("rstfull_in_ready", 32'(in_ready), 32'h0);
        tick();
        chk("rstfull_out_valid", 32'(out_valid), 32'h0);
        chk("rstfull_out_data", 32'(out_data), 32'h0);
        chk("rstfull_sel", 32'(sel), 32'h0);
        rst = 1'b0;
        #1;
        chk("postrst_in_ready", 32'(in_ready), 32'b0001);
        tick();
        chk("postrst_sel", 32'(sel), 32'h0);
        chk("postrst_out_data", 32'(out_data), 32'hA);
        chk("postrst_out_valid", 32'(out_valid), 32'h1);

        // ---- random traffic against a reference model ----
        rst = 1'b1;
        tick();
        rst    = 1'b0;
        m_ptr  = 2'd0;
        m_full = 1'b0;
        m_data = '0;
        m_sel  = 2'd0;
        for (int i = 0; i < 4; i++) begin
            sent[i]  = 0;
            recv[i]  = 0;
            waits[i] = 0;
        end
        for (int cyc = 0; cyc < 1000; cyc++) begin
            in_valid  = 4'($urandom_range(0, 15));
            out_ready = 1'($urandom_range(0, 1));
            in_data   = 16'($urandom);
            #1;
            m_slot = !m_full || out_ready;
            m_gnt  = 1'b0;
            m_gidx = 2'd0;
            if (m_slot) begin
                for (int k = 3; k >= 0; k--) begin
                    if (in_valid[2'(m_ptr + 2'(k))]) begin
                        m_gnt  = 1'b1;
                        m_gidx = 2'(m_ptr + 2'(k));
                    end
                end
            end
            m_rdy = m_gnt ? (4'b0001 << m_gidx) : 4'b0000;
            chk("rnd_in_ready", 32'(in_ready), 32'(m_rdy));
            chk("rnd_onehot", 32'($countones(in_ready) <= 1), 32'h1);
            if (m_full && out_ready) recv[m_sel]++;
            for (int i = 0; i < 4; i++) begin
                if (!in_valid[i] || (m_gnt && m_gidx == 2'(i))) waits[i] = 0;
                else if (m_gnt) waits[i]++;
                chk("rnd_starve", 32'(waits[i] <= 3), 32'h1);
            end
            if (m_gnt) begin
                m_full = 1'b1;
                m_data = in_data[m_gidx];
                m_sel  = m_gidx;
                m_ptr  = m_gidx + 2'd1;
                sent[m_gidx]++;
            end else if (m_slot) begin
                m_full = 1'b0;
            end
            tick();
            chk("rnd_out_valid", 32'(out_valid), 32'(m_full));
            chk("rnd_out_data", 32'(out_data), 32'(m_data));
            chk("rnd_sel", 32'(sel), 32'(m_sel));
        end
        for (int i = 0; i < 4; i++) begin
            chk("rnd_scoreboard", 32'(recv[i]),
                32'(sent[i] - ((m_full && m_sel == 2'(i)) ? 1 : 0)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
